// File: rtl/id_ex_stage_pkg.sv
// Shared decode constants for the ID/EX stage: RV32 opcodes and immediate formats.
package id_ex_stage_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ, ImmNone} imm_fmt_e;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OPC_LUI, OPC_AUIPC:            fmt = ImmU;
            OPC_JAL:                       fmt = ImmJ;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: fmt = ImmI;
            OPC_STORE:                     fmt = ImmS;
            OPC_BRANCH:                    fmt = ImmB;
            default:                       fmt = ImmNone;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline-register bus: registered slot from ID plus EX back-pressure and flush.
interface id_ex_stage_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              ex_stall;
    logic              flush;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc;
    logic [31:0]       ex_instr;
    logic [DATA_W-1:0] ex_rs1_data;
    logic [DATA_W-1:0] ex_rs2_data;
    logic [DATA_W-1:0] ex_imm;
    logic [4:0]        ex_rd;
    logic              ex_pred_taken;

    modport master (
        input  ex_stall, flush,
        output ex_valid, ex_pc, ex_instr, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_pred_taken
    );

    modport slave (
        output ex_stall, flush,
        input  ex_valid, ex_pc, ex_instr, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_pred_taken
    );
endinterface

// File: rtl/id_ex_stage_imm_gen.sv
// Combinational immediate generator: I/S/B/U/J formats sign-extended from instr[31].
module id_ex_stage_imm_gen
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [31:0]       instr,
    output logic [DATA_W-1:0] imm
);
    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_fmt(instr[6:0]))
            ImmI:    imm32 = {{20{instr[31]}}, instr[31:20]};
            ImmS:    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            ImmB:    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            ImmU:    imm32 = {instr[31:12], 12'b0};
            ImmJ:    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = DATA_W'($signed(imm32));
endmodule

// File: rtl/id_ex_stage.sv
// Decode stage: rf read ports, load-use / EX-stall / flush control and the ID/EX register.
// Define ID_EX_PERF_CNT_EN to add the o_bubble_cnt / o_flush_cnt performance counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter bit          LOAD_USE_STALL = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [31:0]       i_instr,
    input  logic              i_pred_taken,
    output logic [4:0]        o_rs1_raddr,
    output logic [4:0]        o_rs2_raddr,
    output logic              o_rf_valid,
    input  logic [DATA_W-1:0] i_rs1_rdata,
    input  logic [DATA_W-1:0] i_rs2_rdata,
    input  logic              i_wb_wen,
    input  logic [4:0]        i_wb_waddr,
    input  logic [DATA_W-1:0] i_wb_wdata,
    output logic              o_id_stall,
    id_ex_stage_if.master     ex_bus
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       o_bubble_cnt,
    output logic [31:0]       o_flush_cnt
`endif
);
    logic [6:0]        opcode;
    logic              uses_rs1, uses_rs2, has_rd, load_use;
    logic              snoop_rs1, snoop_rs2;
    logic [DATA_W-1:0] imm;

    logic              valid_q, pred_q;
    logic [DATA_W-1:0] pc_q, rs1_q, rs2_q, imm_q;
    logic [31:0]       instr_q;
    logic [4:0]        rd_q;

    assign opcode      = i_instr[6:0];
    assign o_rs1_raddr = i_instr[19:15];
    assign o_rs2_raddr = i_instr[24:20];
    assign o_rf_valid  = i_valid;

    assign uses_rs1 = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
    assign uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    assign has_rd   = !(opcode == OPC_STORE || opcode == OPC_BRANCH);

    // Bubble exactly once: after the bubble the EX slot is invalid, so the hazard clears.
    assign load_use = LOAD_USE_STALL && valid_q && (instr_q[6:0] == OPC_LOAD) && (rd_q != 5'd0)
                      && i_valid && ((uses_rs1 && o_rs1_raddr == rd_q) ||
                                     (uses_rs2 && o_rs2_raddr == rd_q));

    assign o_id_stall = i_valid && (ex_bus.ex_stall || load_use) && !ex_bus.flush;

    // Operands held under EX stall must still see writebacks that land meanwhile.
    assign snoop_rs1 = i_wb_wen && (i_wb_waddr != 5'd0) && (i_wb_waddr == instr_q[19:15]);
    assign snoop_rs2 = i_wb_wen && (i_wb_waddr != 5'd0) && (i_wb_waddr == instr_q[24:20]);

    id_ex_stage_imm_gen #(
        .DATA_W (DATA_W)
    ) u_imm_gen (
        .instr (i_instr),
        .imm   (imm)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            pred_q  <= 1'b0;
        end else if (ex_bus.flush) begin
            valid_q <= 1'b0;
        end else if (ex_bus.ex_stall) begin
            if (snoop_rs1) rs1_q <= i_wb_wdata;
            if (snoop_rs2) rs2_q <= i_wb_wdata;
        end else if (load_use) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= i_valid;
            pc_q    <= i_pc;
            instr_q <= i_instr;
            rs1_q   <= i_rs1_rdata;
            rs2_q   <= i_rs2_rdata;
            imm_q   <= imm;
            rd_q    <= has_rd ? i_instr[11:7] : 5'd0;
            pred_q  <= i_pred_taken;
        end
    end

    assign ex_bus.ex_valid      = valid_q;
    assign ex_bus.ex_pc         = pc_q;
    assign ex_bus.ex_instr      = instr_q;
    assign ex_bus.ex_rs1_data   = rs1_q;
    assign ex_bus.ex_rs2_data   = rs2_q;
    assign ex_bus.ex_imm        = imm_q;
    assign ex_bus.ex_rd         = rd_q;
    assign ex_bus.ex_pred_taken = pred_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, flush_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (!ex_bus.flush && !ex_bus.ex_stall && load_use) bubble_cnt_q <= bubble_cnt_q + 32'd1;
            if (ex_bus.flush && valid_q) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign o_bubble_cnt = bubble_cnt_q;
    assign o_flush_cnt  = flush_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus hand sequences for stall/flush/reset.
module tb_id_ex_stage;
    localparam logic [31:0] I_LUI_X5  = 32'h123452B7;
    localparam logic [31:0] I_BEQ_M4  = 32'hFE000EE3;
    localparam logic [31:0] I_SW_M8   = 32'hFE20AC23;
    localparam logic [31:0] I_LW_X5   = 32'h0000A283;
    localparam logic [31:0] I_LW_X0   = 32'h0000A003;
    localparam logic [31:0] I_LW_X2   = 32'h0000A103;
    localparam logic [31:0] I_LW_X6   = 32'h0002A303;
    localparam logic [31:0] I_ADD_652 = 32'h00228333;
    localparam logic [31:0] I_ADD_637 = 32'h00718333;
    localparam logic [31:0] I_JAL_8   = 32'h008000EF;
    localparam logic [31:0] I_ADDI_M1 = 32'hFFF00393;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, pred, wb_wen;
    logic [31:0] pc, instr, rs1_rdata, rs2_rdata, wb_wdata;
    logic [4:0]  wb_waddr, rs1_raddr, rs2_raddr;
    logic        rf_valid, id_stall;
    logic [31:0] bubble_cnt, flush_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    id_ex_stage_if #(.DATA_W(32)) ex_bus ();

    id_ex_stage #(
        .DATA_W         (32),
        .LOAD_USE_STALL (1'b1)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (in_valid),
        .i_pc         (pc),
        .i_instr      (instr),
        .i_pred_taken (pred),
        .o_rs1_raddr  (rs1_raddr),
        .o_rs2_raddr  (rs2_raddr),
        .o_rf_valid   (rf_valid),
        .i_rs1_rdata  (rs1_rdata),
        .i_rs2_rdata  (rs2_rdata),
        .i_wb_wen     (wb_wen),
        .i_wb_waddr   (wb_waddr),
        .i_wb_wdata   (wb_wdata),
        .o_id_stall   (id_stall),
        .ex_bus       (ex_bus)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .o_bubble_cnt (bubble_cnt),
        .o_flush_cnt  (flush_cnt)
`endif
    );

`ifndef ID_EX_PERF_CNT_EN
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic        exp_stall;
        logic        exp_valid;
        logic        chk_fields;
        logic [4:0]  exp_rd;
        logic [31:0] exp_imm;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] d1, input logic [31:0] d2, input logic exs,
                         input logic fl, input logic wen, input logic [4:0] wa,
                         input logic [31:0] wd);
        in_valid = v; instr = ins; pc = p; pred = p[2];
        rs1_rdata = d1; rs2_rdata = d2;
        ex_bus.ex_stall = exs; ex_bus.flush = fl;
        wb_wen = wen; wb_waddr = wa; wb_wdata = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " valid"}, {31'd0, ex_bus.ex_valid}, 32'd0);
        chk({tag, " pc"}, ex_bus.ex_pc, 32'd0);
        chk({tag, " instr"}, ex_bus.ex_instr, 32'd0);
        chk({tag, " rs1"}, ex_bus.ex_rs1_data, 32'd0);
        chk({tag, " rs2"}, ex_bus.ex_rs2_data, 32'd0);
        chk({tag, " imm"}, ex_bus.ex_imm, 32'd0);
        chk({tag, " rd"}, {27'd0, ex_bus.ex_rd}, 32'd0);
        chk({tag, " pred"}, {31'd0, ex_bus.ex_pred_taken}, 32'd0);
    endtask

    initial begin
        //            valid instr      stall exv chk rd    imm
        vecs[0]  = '{1'b1, I_LUI_X5,  1'b0, 1'b1, 1'b1, 5'd5, 32'h12345000};
        vecs[1]  = '{1'b1, I_BEQ_M4,  1'b0, 1'b1, 1'b1, 5'd0, 32'hFFFFFFFC};
        vecs[2]  = '{1'b1, I_SW_M8,   1'b0, 1'b1, 1'b1, 5'd0, 32'hFFFFFFF8};
        vecs[3]  = '{1'b1, I_LW_X5,   1'b0, 1'b1, 1'b1, 5'd5, 32'h00000000};
        vecs[4]  = '{1'b1, I_ADD_652, 1'b1, 1'b0, 1'b0, 5'd0, 32'h00000000};
        vecs[5]  = '{1'b1, I_ADD_652, 1'b0, 1'b1, 1'b1, 5'd6, 32'h00000000};
        vecs[6]  = '{1'b1, I_LW_X0,   1'b0, 1'b1, 1'b1, 5'd0, 32'h00000000};
        vecs[7]  = '{1'b1, I_ADD_652, 1'b0, 1'b1, 1'b1, 5'd6, 32'h00000000};
        vecs[8]  = '{1'b1, I_LW_X5,   1'b0, 1'b1, 1'b1, 5'd5, 32'h00000000};
        vecs[9]  = '{1'b1, I_LUI_X5,  1'b0, 1'b1, 1'b1, 5'd5, 32'h12345000};
        vecs[10] = '{1'b1, I_LW_X5,   1'b0, 1'b1, 1'b1, 5'd5, 32'h00000000};
        vecs[11] = '{1'b1, I_LW_X6,   1'b1, 1'b0, 1'b0, 5'd0, 32'h00000000};
        vecs[12] = '{1'b1, I_LW_X6,   1'b0, 1'b1, 1'b1, 5'd6, 32'h00000000};
        vecs[13] = '{1'b1, I_JAL_8,   1'b0, 1'b1, 1'b1, 5'd1, 32'h00000008};
        vecs[14] = '{1'b0, I_ADDI_M1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h00000000};
        vecs[15] = '{1'b1, I_ADDI_M1, 1'b0, 1'b1, 1'b1, 5'd7, 32'hFFFFFFFF};
        vecs[16] = '{1'b1, I_LW_X2,   1'b0, 1'b1, 1'b1, 5'd2, 32'h00000000};
        vecs[17] = '{1'b1, I_SW_M8,   1'b1, 1'b0, 1'b0, 5'd0, 32'h00000000};
        vecs[18] = '{1'b1, I_SW_M8,   1'b0, 1'b1, 1'b1, 5'd0, 32'hFFFFFFF8};

        rst = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            logic [31:0] p, d1, d2;
            string       t;
            p  = 32'h1000 + 32'(4 * i);
            d1 = 32'hA000_0000 + 32'(i);
            d2 = 32'hB000_0000 + 32'(i);
            t  = $sformatf("vec%0d", i);
            drive(vecs[i].valid, vecs[i].instr, p, d1, d2, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
            #1;
            chk({t, " rs1_raddr"}, {27'd0, rs1_raddr}, {27'd0, vecs[i].instr[19:15]});
            chk({t, " rs2_raddr"}, {27'd0, rs2_raddr}, {27'd0, vecs[i].instr[24:20]});
            chk({t, " rf_valid"}, {31'd0, rf_valid}, {31'd0, vecs[i].valid});
            chk({t, " id_stall"}, {31'd0, id_stall}, {31'd0, vecs[i].exp_stall});
            step();
            chk({t, " ex_valid"}, {31'd0, ex_bus.ex_valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].chk_fields) begin
                chk({t, " ex_rd"}, {27'd0, ex_bus.ex_rd}, {27'd0, vecs[i].exp_rd});
                chk({t, " ex_imm"}, ex_bus.ex_imm, vecs[i].exp_imm);
                chk({t, " ex_pc"}, ex_bus.ex_pc, p);
                chk({t, " ex_instr"}, ex_bus.ex_instr, vecs[i].instr);
                chk({t, " ex_rs1"}, ex_bus.ex_rs1_data, d1);
                chk({t, " ex_rs2"}, ex_bus.ex_rs2_data, d2);
                chk({t, " ex_pred"}, {31'd0, ex_bus.ex_pred_taken}, {31'd0, p[2]});
            end
        end

        // EX stall holds the slot while writeback to x7 is snooped into rs2
        drive(1'b1, I_ADD_637, 32'h2000, 32'h33, 32'h77, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        chk("snoop setup rs2", ex_bus.ex_rs2_data, 32'h77);
        drive(1'b1, I_LUI_X5, 32'h2004, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd7, 32'hDEADBEEF);
        #1;
        chk("ex_stall id_stall", {31'd0, id_stall}, 32'd1);
        step();
        chk("snoop rs2", ex_bus.ex_rs2_data, 32'hDEADBEEF);
        chk("snoop rs1 held", ex_bus.ex_rs1_data, 32'h33);
        chk("snoop pc held", ex_bus.ex_pc, 32'h2000);
        chk("snoop instr held", ex_bus.ex_instr, I_ADD_637);
        chk("snoop rd held", {27'd0, ex_bus.ex_rd}, 32'd6);
        chk("snoop valid held", {31'd0, ex_bus.ex_valid}, 32'd1);
        drive(1'b1, I_LUI_X5, 32'h2004, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd0, 32'h12345678);
        step();
        chk("snoop x0 rs2", ex_bus.ex_rs2_data, 32'hDEADBEEF);
        chk("snoop x0 rs1", ex_bus.ex_rs1_data, 32'h33);

        // Flush outranks EX stall and a live load-use hazard
        drive(1'b1, I_LW_X5, 32'h3000, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        chk("flush setup valid", {31'd0, ex_bus.ex_valid}, 32'd1);
        drive(1'b1, I_ADD_652, 32'h3004, 32'h1, 32'h2, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        #1;
        chk("flush id_stall", {31'd0, id_stall}, 32'd0);
        step();
        chk("flush ex_valid", {31'd0, ex_bus.ex_valid}, 32'd0);

        // Reset mid-stream with a valid slot
        drive(1'b1, I_LUI_X5, 32'h4000, 32'h5, 32'h6, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        chk("pre-reset valid", {31'd0, ex_bus.ex_valid}, 32'd1);
        rst = 1'b1;
        step();
        chk_all_zero("midreset");
        drive(1'b1, I_ADD_652, 32'h4004, 32'h5, 32'h6, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("midreset id_stall", {31'd0, id_stall}, 32'd0);
        rst = 1'b0;

`ifdef ID_EX_PERF_CNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("bubble_cnt reset", bubble_cnt, 32'd0);
        chk("flush_cnt reset", flush_cnt, 32'd0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, I_LW_X5, 32'h5000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
            step();
            drive(1'b1, I_ADD_652, 32'h5004, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
            step();
            step();
        end
        drive(1'b1, I_LUI_X5, 32'h5008, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        step();
        drive(1'b1, I_LUI_X5, 32'h5008, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        drive(1'b1, I_LUI_X5, 32'h5008, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        step();
        step();
        chk("bubble_cnt", bubble_cnt, 32'd3);
        chk("flush_cnt", flush_cnt, 32'd2);
`else
        chk("counters absent bubble", bubble_cnt, 32'd0);
        chk("counters absent flush", flush_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
